// File: rtl/crc_mem_reader_if.sv
// Avalon-MM style bus bundle, used both for the CSR slave port and the
// memory master port of crc_mem_reader.
// Signals: address/read/write/writedata toward the slave, readdata/
// waitrequest/readdatavalid back toward the master. AW sets address width.
interface crc_mem_reader_if #(
  parameter int AW = 32
);
  logic [AW-1:0] address;
  logic          read;
  logic          write;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic          waitrequest;
  logic          readdatavalid;

  modport master (
    output address, read, write, writedata,
    input  readdata, waitrequest, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata,
    output readdata, waitrequest, readdatavalid
  );
endinterface

// File: rtl/crc_mem_reader.sv
// CRC-32/IEEE engine that reads a block of words from on-chip RAM through
// its own master port; software sets START/LEN over the CSR port and starts it.
// Ports: clk, reset_n (async, active low), csr (slave: 2-bit word select,
// read latency 1), mem (master: byte address, one read outstanding),
// irq (level, done & irq_en).
module crc_mem_reader #(
  parameter int          MEM_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic             clk,
  input  logic             reset_n,
  crc_mem_reader_if.slave  csr,
  crc_mem_reader_if.master mem,
  output logic             irq
);
  localparam int          PTR_W   = $clog2(MEM_WORDS);
  localparam logic [10:0] LEN_MAX = 11'd1024;
  localparam logic [31:0] POLY    = 32'hEDB88320;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  state_t state, state_nxt;

  logic [9:0]       start_reg;
  logic [10:0]      len_reg;
  logic [31:0]      crc_reg;
  logic [31:0]      crc_acc;
  logic [PTR_W-1:0] ptr;
  logic [10:0]      remaining;
  logic             done;
  logic             irq_en;
  logic             busy;
  logic             wr_ctrl;
  logic             start_req;
  logic             take_word;
  logic             last_word;
  logic [31:0]      crc_next;
  logic [31:0]      csr_rdata;
  logic             csr_rvalid;

  // Whole 32-bit word folded in one cycle: bytes little-endian, each byte
  // LSB first, which is simply bit 0 through bit 31 in order.
  function automatic logic [31:0] crc_fold(input logic [31:0] c, input logic [31:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 32; i++) begin
      r = (r >> 1) ^ (((r[0] ^ d[i]) != 1'b0) ? POLY : 32'h0);
    end
    return r;
  endfunction

  assign busy      = (state == REQ) || (state == WAIT);
  assign wr_ctrl   = csr.write && (csr.address == 2'd0);
  // DONE is a pass-through cycle with busy already low, so start is honoured there too.
  assign start_req = wr_ctrl && csr.writedata[0] && !busy;
  assign take_word = (state == WAIT) && mem.readdatavalid;
  assign last_word = take_word && (remaining == 11'd1);
  assign crc_next  = crc_fold(crc_acc, mem.readdata);
  assign irq       = done & irq_en;

  // Master side: a single request at a time, address straight from ptr.
  assign mem.read      = (state == REQ);
  assign mem.address   = BASE_ADDR + (32'(ptr) << 2);
  assign mem.write     = 1'b0;
  assign mem.writedata = 32'h0;

  assign csr.readdata      = csr_rdata;
  assign csr.readdatavalid = csr_rvalid;
  assign csr.waitrequest   = 1'b0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        state_nxt = IDLE;
        if (start_req) begin
          state_nxt = (len_reg == 11'd0) ? DONE : REQ;
        end
      end
      REQ: begin
        if (!mem.waitrequest) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (mem.readdatavalid) begin
          state_nxt = (remaining == 11'd1) ? DONE : REQ;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Run datapath and status flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr       <= '0;
      remaining <= '0;
      crc_acc   <= '0;
      crc_reg   <= '0;
      done      <= 1'b0;
    end else begin
      if (start_req) begin
        ptr       <= PTR_W'(32'(start_reg) % MEM_WORDS);
        remaining <= len_reg;
        crc_acc   <= 32'hFFFF_FFFF;
        if (len_reg == 11'd0) begin
          crc_reg <= 32'h0;
        end
      end else if (take_word) begin
        crc_acc   <= crc_next;
        ptr       <= (ptr == PTR_W'(MEM_WORDS - 1)) ? '0 : ptr + 1'b1;
        remaining <= remaining - 11'd1;
        if (remaining == 11'd1) begin
          crc_reg <= ~crc_next;
        end
      end

      // Starting clears done, except an empty run which completes at once.
      if (start_req) begin
        done <= (len_reg == 11'd0);
      end else if (last_word) begin
        done <= 1'b1;
      end else if (wr_ctrl && !csr.writedata[0]) begin
        done <= 1'b0;
      end
    end
  end

  // CSR registers and registered read port.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      start_reg  <= '0;
      len_reg    <= '0;
      irq_en     <= 1'b0;
      csr_rdata  <= '0;
      csr_rvalid <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        irq_en <= csr.writedata[1];
      end
      if (csr.write && !busy) begin
        if (csr.address == 2'd1) begin
          start_reg <= csr.writedata[9:0];
        end
        if (csr.address == 2'd2) begin
          len_reg <= (csr.writedata > 32'd1024) ? LEN_MAX : csr.writedata[10:0];
        end
      end

      csr_rvalid <= csr.read;
      if (csr.read) begin
        case (csr.address)
          2'd0:    csr_rdata <= {29'd0, irq_en, done, busy};
          2'd1:    csr_rdata <= {22'd0, start_reg};
          2'd2:    csr_rdata <= {21'd0, len_reg};
          default: csr_rdata <= crc_reg;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_crc_mem_reader.sv
// Bench for crc_mem_reader: random memory contents, random stalls/latency,
// scoreboarded CSR reads and master addresses against a byte-wise CRC model.
module tb_crc_mem_reader;
  localparam logic [31:0] BASE = 32'h0000_4000;

  logic clk = 1'b0;
  logic reset_n;
  logic irq;

  always #5 clk = ~clk;

  crc_mem_reader_if #(.AW(2))  csr_bus ();
  crc_mem_reader_if #(.AW(32)) mem_bus ();

  crc_mem_reader #(.MEM_WORDS(1024), .BASE_ADDR(BASE)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .csr     (csr_bus),
    .mem     (mem_bus),
    .irq     (irq)
  );

  logic [31:0] ram [1024];
  int n_chk  = 0;
  int n_fail = 0;

  // Scoreboards
  bit          rd_chk_q  [$];
  logic [31:0] rd_val_q  [$];
  string       rd_name_q [$];
  logic [31:0] exp_addr_q[$];

  // Responder knobs / state
  int stall_max = 0;
  int lat_max   = 1;
  int rdv_cnt   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: CRC-32/IEEE processed byte by byte, little-endian bytes.
  function automatic logic [31:0] ref_crc(input int st, input int len);
    logic [31:0] c;
    logic [31:0] w;
    logic [7:0]  b;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < len; i++) begin
      w = ram[(st + i) % 1024];
      for (int k = 0; k < 4; k++) begin
        b = w[8*k +: 8];
        c = c ^ {24'd0, b};
        for (int j = 0; j < 8; j++) begin
          c = (c[0] == 1'b1) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
      end
    end
    return c ^ 32'hFFFF_FFFF;
  endfunction

  // Memory slave model: random waitrequest, random readdata latency.
  initial begin
    bit          in_req;
    bit          pend;
    bit          acc_prev;
    int          stall;
    int          pend_cnt;
    int          pend_idx;
    logic [31:0] req_addr;
    in_req = 0; pend = 0; acc_prev = 0; stall = 0; pend_cnt = 0; pend_idx = 0; req_addr = '0;
    mem_bus.waitrequest   = 1'b0;
    mem_bus.readdatavalid = 1'b0;
    mem_bus.readdata      = 32'h0;
    forever begin
      @(negedge clk);
      if (reset_n !== 1'b1) begin
        in_req = 0; pend = 0; acc_prev = 0;
        mem_bus.waitrequest   = 1'b0;
        mem_bus.readdatavalid = 1'b0;
        continue;
      end
      if (acc_prev) begin
        pend = 1;
        pend_cnt = int'($urandom_range(lat_max, 1));
      end
      acc_prev = 0;
      mem_bus.readdatavalid = 1'b0;
      mem_bus.readdata      = $urandom;
      if (pend) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          pend = 0;
          mem_bus.readdatavalid = 1'b1;
          mem_bus.readdata      = ram[pend_idx];
          rdv_cnt++;
        end
      end
      mem_bus.waitrequest = 1'b0;
      if (mem_bus.read === 1'b1) begin
        if (!in_req) begin
          in_req   = 1;
          stall    = int'($urandom_range(stall_max, 0));
          req_addr = mem_bus.address;
          if (exp_addr_q.size() == 0) check("unexpected_m_read", 32'd1, 32'd0);
          else check("m_address", req_addr, exp_addr_q.pop_front());
        end else begin
          check("m_address_stall", mem_bus.address, req_addr);
        end
        if (stall > 0) begin
          mem_bus.waitrequest = 1'b1;
          stall--;
        end else begin
          in_req   = 0;
          acc_prev = 1;
          pend_idx = int'((req_addr - BASE) >> 2) % 1024;
        end
      end
    end
  end

  // CSR read monitor: pops the scoreboard whenever read data is presented.
  initial begin
    bit          c;
    logic [31:0] v;
    string       n;
    forever begin
      @(negedge clk);
      if (csr_bus.readdatavalid === 1'b1) begin
        if (rd_val_q.size() == 0) begin
          check("csr_unexpected_rdv", 32'd1, 32'd0);
        end else begin
          c = rd_chk_q.pop_front();
          v = rd_val_q.pop_front();
          n = rd_name_q.pop_front();
          if (c) check(n, csr_bus.readdata, v);
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic csr_write(input logic [1:0] a, input logic [31:0] d);
    csr_bus.address   = a;
    csr_bus.writedata = d;
    csr_bus.write     = 1'b1;
    @(negedge clk);
    csr_bus.write     = 1'b0;
  endtask

  // Returns on the negedge where the read data is on the bus.
  task automatic csr_read(input logic [1:0] a, input bit chk, input logic [31:0] exp, input string name);
    rd_chk_q.push_back(chk);
    rd_val_q.push_back(exp);
    rd_name_q.push_back(name);
    csr_bus.address = a;
    csr_bus.read    = 1'b1;
    @(negedge clk);
    csr_bus.read    = 1'b0;
  endtask

  task automatic start_run(input int st, input int ln, input logic [31:0] ctrl,
                           output logic [31:0] exp_crc, output int eff);
    eff = (ln > 1024) ? 1024 : ln;
    for (int i = 0; i < eff; i++) exp_addr_q.push_back(BASE + 32'(((st + i) % 1024) * 4));
    exp_crc = ref_crc(st, eff);
    csr_write(2'd1, 32'(st));
    csr_write(2'd2, 32'(ln));
    csr_write(2'd0, ctrl);
  endtask

  // Counts cycles from the cycle after the start write until irq is seen.
  task automatic wait_irq(input int limit, output int cyc);
    cyc = 1;
    while (irq !== 1'b1 && cyc < limit) begin
      @(negedge clk);
      cyc++;
    end
    if (irq !== 1'b1) check("irq_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_check(input string tag, input int st, input int ln, input bit timed);
    logic [31:0] e;
    int eff, cyc;
    start_run(st, ln, 32'd3, e, eff);
    wait_irq(6000, cyc);
    if (timed) check({tag, "_cycles"}, 32'(cyc), 32'(2 * eff + 1));
    csr_read(2'd3, 1'b1, e, {tag, "_crc"});
    csr_read(2'd0, 1'b1, 32'd6, {tag, "_status"});
    check({tag, "_addr_left"}, 32'(exp_addr_q.size()), 32'd0);
  endtask

  initial begin
    logic [31:0] e;
    int eff, cyc, base;
    reset_n = 1'b0;
    csr_bus.address = '0; csr_bus.read = 1'b0; csr_bus.write = 1'b0; csr_bus.writedata = '0;
    for (int i = 0; i < 1024; i++) ram[i] = $urandom;
    repeat (3) @(negedge clk);
    check("rst_m_read", 32'(mem_bus.read), 32'd0);
    check("rst_m_address", mem_bus.address, BASE);
    check("rst_irq", 32'(irq), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    for (int r = 0; r < 4; r++) csr_read(2'(r), 1'b1, 32'd0, $sformatf("rst_reg%0d", r));

    // Known-answer runs, zero-wait latency-1 slave.
    ram[0] = 32'h3433_3231;
    run_check("kat_1234", 0, 1, 1'b1);
    csr_read(2'd3, 1'b1, 32'h9BE3_E0A3, "kat_1234_const");
    ram[0] = 32'h0;
    run_check("kat_zero", 0, 1, 1'b1);
    csr_read(2'd3, 1'b1, 32'h2144_DF1C, "kat_zero_const");
    run_check("len0", 5, 0, 1'b1);
    csr_read(2'd3, 1'b1, 32'h0, "len0_const");

    // Address wrap, then same run with stalls.
    ram[0] = $urandom;
    run_check("wrap", 1020, 8, 1'b1);
    stall_max = 5; lat_max = 4;
    run_check("wrap_stall", 1020, 8, 1'b0);
    for (int t = 0; t < 6; t++)
      run_check($sformatf("rand%0d", t), int'($urandom_range(1023, 0)), int'($urandom_range(40, 1)), 1'b0);

    // Writes while busy are ignored.
    start_run(100, 8, 32'd3, e, eff);
    csr_read(2'd0, 1'b1, 32'd5, "busy_status");
    csr_write(2'd2, 32'd3);
    csr_write(2'd1, 32'd7);
    csr_write(2'd0, 32'd3);
    wait_irq(3000, cyc);
    csr_read(2'd3, 1'b1, e, "busy_crc");
    csr_read(2'd2, 1'b1, 32'd8, "busy_len_kept");
    csr_read(2'd1, 1'b1, 32'd100, "busy_start_kept");
    repeat (20) @(negedge clk);
    check("busy_no_rerun", 32'(exp_addr_q.size()), 32'd0);

    // Clearing done via reg0=0 drops irq.
    csr_write(2'd0, 32'd0);
    check("irq_cleared", 32'(irq), 32'd0);
    csr_read(2'd0, 1'b1, 32'd0, "cleared_status");

    // Polled run with irq disabled.
    start_run(333, 17, 32'd1, e, eff);
    cyc = 0;
    do begin
      csr_read(2'd0, 1'b0, 32'd0, "poll");
      cyc++;
    end while (csr_bus.readdata[1] !== 1'b1 && cyc < 3000);
    check("poll_done", 32'(csr_bus.readdata[1]), 32'd1);
    check("poll_irq_low", 32'(irq), 32'd0);
    csr_read(2'd0, 1'b1, 32'd2, "poll_status");
    csr_read(2'd3, 1'b1, e, "poll_crc");

    // LEN saturation and a full-memory run.
    stall_max = 0; lat_max = 1;
    csr_write(2'd2, 32'd5000);
    csr_read(2'd2, 1'b1, 32'd1024, "len_sat");
    run_check("full", int'($urandom_range(1023, 0)), 5000, 1'b1);

    // Reset in the middle of a run.
    base = rdv_cnt;
    start_run(200, 16, 32'd3, e, eff);
    cyc = 0;
    while (rdv_cnt < base + 5 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    check("midrst_reached", 32'(rdv_cnt >= base + 5), 32'd1);
    reset_n = 1'b0;
    #1;
    check("midrst_m_read", 32'(mem_bus.read), 32'd0);
    check("midrst_irq", 32'(irq), 32'd0);
    exp_addr_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    csr_read(2'd0, 1'b1, 32'd0, "midrst_status");
    csr_read(2'd3, 1'b1, 32'd0, "midrst_crc");
    repeat (10) @(negedge clk);
    check("midrst_no_req", 32'(mem_bus.read), 32'd0);
    run_check("post_rst", 200, 16, 1'b1);

    repeat (10) @(negedge clk);
    check("csr_sb_empty", 32'(rd_val_q.size()), 32'd0);
    check("addr_sb_empty", 32'(exp_addr_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
